// File: rtl/and_sweep_ctrl.sv
// Self-test sequencer for a two-input AND gate: sweeps a/b through 00..11,
// captures y into a truth table and compares it against EXPECTED.
// Optional: define AND_SWEEP_SYNC_IN_EN to pass y_in through a 2-flop synchronizer.
module and_sweep_ctrl #(
  parameter int         DWELL    = 4,
  parameter logic [3:0] EXPECTED = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] table_out
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0] RELOAD = 8'(DWELL - 1);

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [3:0] tbl, tbl_nxt;
  logic [3:0] table_nxt;
  logic       done_nxt, pass_nxt, run_nxt;
  logic       y_s;

`ifdef AND_SWEEP_SYNC_IN_EN
  // y_in may be asynchronous to clk; sampled value lags two edges.
  logic [1:0] sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], y_in};
  end
  assign y_s = sync_q[1];
`else
  assign y_s = y_in;
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    tbl_nxt   = tbl;
    table_nxt = table_out;
    pass_nxt  = pass;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          idx_nxt   = 2'd0;
          cnt_nxt   = RELOAD;
          tbl_nxt   = 4'd0;
        end
      end
      RUN: begin
        if (cnt != 8'd0) begin
          cnt_nxt = cnt - 8'd1;
        end else begin
          tbl_nxt[idx] = y_s;
          cnt_nxt      = RELOAD;
          if (idx != 2'd3) begin
            idx_nxt = idx + 2'd1;
          end else begin
            state_nxt = IDLE;
            table_nxt = tbl_nxt;
            pass_nxt  = (tbl_nxt == EXPECTED);
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    run_nxt = (state_nxt == RUN);
  end

  // Stimulus outputs are registered from next-state so they change on the same edge as idx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 2'd0;
      cnt       <= 8'd0;
      tbl       <= 4'd0;
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      table_out <= 4'd0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      tbl       <= tbl_nxt;
      a_out     <= run_nxt & idx_nxt[1];
      b_out     <= run_nxt & idx_nxt[0];
      busy      <= run_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      table_out <= table_nxt;
    end
  end

endmodule

// File: tb/tb_and_sweep_ctrl.sv
// Directed bench for and_sweep_ctrl: reset, nominal, stuck-at, held start,
// mid-sweep reset, and a DWELL=1 instance.
module tb_and_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, start1, tog;
  int   ymode;
  logic y_in, a_out, b_out, busy, done, pass;
  logic [3:0] table_out;
  logic y_in1, a1, b1, busy1, done1, pass1;
  logic [3:0] table1;

  // ymode: 0 = healthy AND gate, 1 = stuck-at-1, 2 = toggling noise
  assign y_in  = (ymode == 2) ? tog : (ymode == 1) ? 1'b1 : (a_out & b_out);
  assign y_in1 = a1 & b1;

  and_sweep_ctrl #(.DWELL(4), .EXPECTED(4'b1000)) u_dut (
    .clk(clk), .rst(rst), .start(start), .y_in(y_in),
    .a_out(a_out), .b_out(b_out), .busy(busy), .done(done),
    .pass(pass), .table_out(table_out));

  and_sweep_ctrl #(.DWELL(1), .EXPECTED(4'b1000)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .y_in(y_in1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1),
    .pass(pass1), .table_out(table1));

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] last_tbl;
  logic       last_pass;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the start edge T; returns #1 after edge T+16.
  task automatic sweep(input logic [3:0] etbl, input logic epass);
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < 4; d++) begin
        chk("busy_run", 8'(busy), 8'd1);
        chk("ab_seq", 8'({a_out, b_out}), 8'(k));
        chk("done_run", 8'(done), 8'd0);
        chk("tbl_hold", 8'(table_out), 8'(last_tbl));
        chk("pass_hold", 8'(pass), 8'(last_pass));
        tick;
      end
    end
    chk("done_end", 8'(done), 8'd1);
    chk("busy_end", 8'(busy), 8'd0);
    chk("ab_end", 8'({a_out, b_out}), 8'd0);
    chk("tbl_end", 8'(table_out), 8'(etbl));
    chk("pass_end", 8'(pass), 8'(epass));
    last_tbl  = etbl;
    last_pass = epass;
  endtask

  logic [3:0] exp_tbl1;
  logic       exp_pass1;

  initial begin
    rst = 1'b1; start = 1'b1; start1 = 1'b1; ymode = 2; tog = 1'b0;
    // 1. reset held with start high and y toggling
    for (int i = 0; i < 6; i++) begin
      tog = ~tog;
      tick;
      chk("rst_hold", {1'b0, a_out, b_out, busy, done, pass, 2'b0} | 8'(table_out), 8'd0);
    end
    start = 1'b0; start1 = 1'b0; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("rst_rel", {1'b0, a_out, b_out, busy, done, pass, 2'b0} | 8'(table_out), 8'd0);
    end
    last_tbl = 4'd0; last_pass = 1'b0;

    // 2. nominal sweep
    ymode = 0;
    start = 1'b1; tick; start = 1'b0;
    sweep(4'b1000, 1'b1);
    tick;
    chk("done_clear", 8'(done), 8'd0);
    chk("idle_busy", 8'(busy), 8'd0);

    // 3. stuck-at-1, then healthy rerun
    ymode = 1;
    start = 1'b1; tick; start = 1'b0;
    sweep(4'b1111, 1'b0);
    tick;
    ymode = 0;
    start = 1'b1; tick; start = 1'b0;
    sweep(4'b1000, 1'b1);
    tick;

    // 4. start held high: back-to-back sweeps, relaunch one edge after done
    start = 1'b1; tick;
    sweep(4'b1000, 1'b1);
    for (int r = 0; r < 2; r++) begin
      tick;
      chk("b2b_done_clear", 8'(done), 8'd0);
      sweep(4'b1000, 1'b1);
    end
    start = 1'b0;
    tick;
    chk("b2b_stop_busy", 8'(busy), 8'd0);
    chk("b2b_stop_done", 8'(done), 8'd0);

    // 5. reset mid-sweep at T+6
    start = 1'b1; tick; start = 1'b0;
    repeat (6) tick;
    chk("mid_busy_pre", 8'(busy), 8'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out", {2'b0, a_out, b_out, busy, pass, 2'b0} | 8'(table_out), 8'd0);
    tick;
    rst = 1'b0;
    last_tbl = 4'd0; last_pass = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("mid_no_done", 8'({busy, done}), 8'd0);
      tick;
    end
    start = 1'b1; tick; start = 1'b0;
    sweep(4'b1000, 1'b1);
    tick;

    // 6. DWELL=1 instance; synchronizer lag breaks capture at this dwell
`ifdef AND_SWEEP_SYNC_IN_EN
    exp_tbl1 = 4'b0000; exp_pass1 = 1'b0;
`else
    exp_tbl1 = 4'b1000; exp_pass1 = 1'b1;
`endif
    start1 = 1'b1; tick; start1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("d1_busy", 8'(busy1), 8'd1);
      chk("d1_ab", 8'({a1, b1}), 8'(k));
      chk("d1_done_run", 8'(done1), 8'd0);
      tick;
    end
    chk("d1_done", 8'(done1), 8'd1);
    chk("d1_busy_end", 8'(busy1), 8'd0);
    chk("d1_tbl", 8'(table1), 8'(exp_tbl1));
    chk("d1_pass", 8'(pass1), 8'(exp_pass1));
    tick;
    chk("d1_done_clear", 8'(done1), 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/and_sweep_ctrl.md
# and_sweep_ctrl

- Self-test sequencer for the two-input AND datapath.
- On a start pulse it drives the gate's `a`/`b` inputs through all four combinations (00, 01, 10, 11), holding each for a programmable number of clock cycles.
- It samples the gate output `y` at the end of each hold and assembles a 4-bit truth table.
- It compares the table against an expected pattern and reports `done`/`pass`.
- It sits between a board-level trigger (button or host) and the gate under test, replacing the hand-written stimulus sequence with synthesizable hardware.

## Interface

Parameters:
- `DWELL`, default 4: cycles each input combination is held; legal range 1..255.
- `EXPECTED`, default 4'b1000: expected truth table; bit index = {a,b}.

Ports:
- `clk` in 1: system clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a sweep; sampled only while idle.
- `y_in` in 1: output of the gate under test.
- `a_out` out 1: drives gate input `a`.
- `b_out` out 1: drives gate input `b`.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when the sweep completes.
- `pass` out 1: result of the last completed sweep.
- `table_out` out 4: captured truth table of the last completed sweep.

## Operation

- States: IDLE, RUN.
- Internal registers:
  - combination index `idx` (2 bits)
  - dwell counter `cnt` (8 bits)
  - capture register `tbl` (4 bits)
- Reset: all of the following are 0:
  - state IDLE
  - `idx`, `cnt`, `tbl`
  - `a_out`, `b_out`, `busy`, `done`, `pass`, `table_out`
- IDLE:
  - `a_out`=`b_out`=0, `busy`=0.
  - `start`=1 at an edge gives, at that edge: state RUN, `busy`=1, `idx`=0, `cnt`=`DWELL`-1, `tbl`=0.
- RUN, each edge:
  - If `cnt`≠0: `cnt` decrements.
  - If `cnt`=0: `tbl[idx]` takes the sampled `y_in`, and `cnt` reloads `DWELL`-1.
  - On that same `cnt`=0 edge, if `idx`≠3: `idx` increments.
  - On that same `cnt`=0 edge, if `idx`=3:
    - state returns to IDLE and `busy`=0.
    - `table_out` = final table including this sample.
    - `pass` = (final table == `EXPECTED`).
    - `done`=1.
- `a_out`=`idx[1]`, `b_out`=`idx[0]` while in RUN, 0 in IDLE. Both are registered; no combinational path from any input.
- `done` is high for exactly one cycle and clears on the next edge.
- `pass` and `table_out` hold until the next sweep completes; a new start does not clear them.
- `start` is ignored while RUN, including when held high continuously.
- `start` high in the cycle `done` is high: that edge launches a new sweep (back-to-back).
- `rst` asserted mid-sweep: immediate return to reset values; no `done` pulse; the partial table is discarded.

## Timing

- `start` is captured at edge T.
- Combination k (k=0..3) is presented on `a_out`/`b_out` from after edge T+k·`DWELL` until edge T+(k+1)·`DWELL`.
- `y_in` for combination k is sampled at edge T+(k+1)·`DWELL`.
- At edge T+4·`DWELL`:
  - `done`, `pass` and `table_out` update.
  - `busy` falls.
  - `a_out`/`b_out` return to 0.
- Start-to-done latency is 4·`DWELL` cycles; `busy` is high for 4·`DWELL` cycles.
- With `DWELL`=1, each combination lasts exactly one cycle. `y_in` must settle combinationally within that cycle.

## Configuration

- `AND_SWEEP_SYNC_IN_EN`
  - Defined: `y_in` passes through a two-flop synchronizer, reset to 0, before sampling.
  - The sampled value reflects `y_in` as it was two edges earlier.
  - `DWELL` must be ≥3 for correct capture.
  - Use this when `y_in` comes from an external pin or another clock domain.
  - Latency and sampling edges are otherwise unchanged.
- Not defined: `y_in` is sampled directly at the edges given under Timing.

## Test plan

1. Reset:
   - Stimulus: assert `rst` with `start`=1 and `y_in` toggling.
   - Required: all outputs stay 0; after release with `start`=0, outputs remain 0.
2. Nominal sweep:
   - Stimulus: `DWELL`=4, `y_in`=`a_out`&`b_out`, one-cycle `start` at edge T.
   - Required:
     - `a_out`/`b_out` sequence 00,01,10,11, each held 4 cycles.
     - `done` pulses at edge T+16, `table_out`=4'b1000, `pass`=1.
     - `busy` is high for exactly 16 cycles.
3. Stuck-at fault:
   - Stimulus: `y_in` tied to 1, `DWELL`=4.
   - Required: `table_out`=4'b1111, `pass`=0, `done` at T+16.
   - Then rerun with a correct gate: `pass` returns to 1.
4. Start handling:
   - Stimulus: `start` held high continuously.
   - Required: the start pulses during RUN are ignored; sweeps run back-to-back, each 16 cycles, with `done` high one cycle each.
5. Reset mid-sweep:
   - Stimulus: assert `rst` at cycle T+6.
   - Required:
     - `busy`, `a_out`, `b_out`, `table_out` and `pass` go to 0 immediately.
     - No `done` pulse.
     - The next `start` gives a full 16-cycle sweep.
6. Build with `AND_SWEEP_SYNC_IN_EN`:
   - Stimulus: `DWELL`=4, correct gate.
   - Required: `table_out`=4'b1000, `pass`=1.
   - Additional check, `DWELL`=1: table does not match, `pass`=0.
